uart_packet_assembler: RTL and testbench
========================================

Name: uart_packet_assembler

Overview:
Parametrised successor to the fixed 4-byte UART packet receiver that feeds eDVS events toward SpiNNaker. It oversamples an asynchronous 8N1 serial line and assembles BYTES_PER_PKT bytes into one packet word. Byte order and bit period are configurable. Compared with the fixed block, it adds start-bit glitch rejection, framing-error detection and an inter-byte timeout that discards partial packets. It sits between the board-level rx pin and the packet router.

Parameters:
CLKS_PER_BIT, 32, clock cycles per serial bit; legal range >= 4.
BYTES_PER_PKT, 4, bytes per packet; legal range >= 1; PW = 8*BYTES_PER_PKT.
MSB_FIRST, 1, 1 = first received byte lands in packet[PW-1:PW-8]; 0 = first byte lands in packet[7:0].
TIMEOUT_BITS, 20, idle bit-times allowed between bytes of one packet before the partial packet is dropped.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
rx_in  in  1  asynchronous serial input; idles high.
vld_out  out  1  one-cycle pulse when packet is updated.
packet  out  PW  last complete packet; held until the next one completes.
byte_vld  out  1  one-cycle pulse per correctly framed byte.
byte_data  out  8  last good byte; valid while byte_vld is high.
frame_err  out  1  one-cycle pulse when the stop bit samples 0.
timeout_err  out  1  one-cycle pulse when a partial packet is discarded.
busy  out  1  high while the FSM is outside IDLE or the byte count is nonzero.

Behaviour:
- Reset values: all outputs 0; both synchroniser flops 1; FSM in IDLE; byte count 0; bit and cycle counters 0.
- rx_in passes through a 2-flop synchroniser. Falling-edge detection compares the synchronised value with its previous value. Synchroniser latency is 2 cycles.
- IDLE: on a detected falling edge, go to START and clear the cycle counter.
- START: at cycle CLKS_PER_BIT/2 (integer division) after the edge, sample the line.
  - Sample 0: go to DATA.
  - Sample 1: glitch; return to IDLE with no outputs asserted.
- DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first into a shift register. After the 8th sample, go to STOP.
- STOP: sample CLKS_PER_BIT cycles after bit 7, then return to IDLE in the same step. The stop bit has no idle wait, so back-to-back frames are accepted.
  - Stop sample 1: pulse byte_vld with byte_data in the next cycle and append the byte to the assembly register; byte count increments.
  - Stop sample 0: pulse frame_err in the next cycle; discard the byte and any partial packet (byte count = 0); packet is unchanged.
- Assembly:
  - MSB_FIRST=1: shift left by 8 and insert the new byte at [7:0]; the first byte ends in the MSBs.
  - MSB_FIRST=0: shift right by 8 and insert at [PW-1:PW-8]; the first byte ends in the LSBs.
- Packet completion: when the byte count reaches BYTES_PER_PKT, packet is loaded and vld_out pulses in the same cycle as the final byte_vld. Byte count wraps to 0.
  - Latency: last stop sample to vld_out = 1 cycle.
  - BYTES_PER_PKT=1: every good byte produces vld_out.
- Timeout:
  - The idle counter runs only in IDLE with byte count != 0; it clears on leaving IDLE and whenever byte count = 0.
  - At TIMEOUT_BITS*CLKS_PER_BIT cycles: byte count = 0, the assembly register is cleared, timeout_err pulses, and packet is unchanged.
  - If terminal count coincides with a falling edge: the timeout is taken first, and the new start bit is still accepted as byte 0 of a new packet.
- Reset asserted mid-frame or mid-packet: on the next edge, everything returns to reset values and the partial data is lost. A line still low when reset is released generates no frame until a fresh falling edge.
- frame_err, timeout_err and vld_out are mutually exclusive per cycle by construction.

Test Plan:
1. Defaults; bit period 320 ns at 10 ns clk; send bytes 0x3B, 0x55, 0x0F, 0x0F with 1 idle bit-time between bytes 3 and 4 -> four byte_vld pulses; one vld_out; packet = 0x3B550F0F; no error pulses.
2. Same stimulus with MSB_FIRST=0 -> packet = 0x0F0F553B. Then send 3 further packets back-to-back (0x55, 0x33, 0xFF, 0xF0 ...) -> 3 vld_out pulses, each 1 cycle after its final stop sample.
3. Send 0x3B, then a frame 0x55 with stop bit 0, then 0x0F, 0x0F, 0x33, 0x0F -> frame_err pulses once; the first vld_out gives packet = 0x0F0F330F (partial packet discarded).
4. Send 0x3B, 0x55, then idle 20*32 cycles -> timeout_err pulses exactly at cycle 640 of idle; packet keeps its prior value; the next 4 bytes form a fresh packet.
5. Drive rx_in low for 8 cycles in IDLE -> no byte_vld, no frame_err; busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
6. Assert reset for 1 cycle mid-DATA of byte 2 -> all outputs 0; the following 4 clean bytes yield exactly one vld_out with the correct packet.

Source files
------------

// File: rtl/uart_packet_assembler.sv
// Oversampling 8N1 UART receiver that assembles BYTES_PER_PKT good bytes into one packet word,
// with start-glitch rejection, framing-error detection and an inter-byte timeout.
module uart_packet_assembler #(
    parameter int CLKS_PER_BIT  = 32,
    parameter int BYTES_PER_PKT = 4,
    parameter int MSB_FIRST     = 1,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_in,
    output logic                         vld_out,
    output logic [8*BYTES_PER_PKT-1:0]   packet,
    output logic                         byte_vld,
    output logic [7:0]                   byte_data,
    output logic                         frame_err,
    output logic                         timeout_err,
    output logic                         busy
);

    localparam int PW     = 8 * BYTES_PER_PKT;
    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W   = $clog2(TO_CYC + 1);
    localparam int BC_W   = $clog2(BYTES_PER_PKT + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_next;
    logic              sync1, sync2, rx_prev;
    logic [1:0]        settle;
    logic              fall;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic [PW-1:0]     assembly;
    logic [PW-1:0]     assembly_next;
    logic [BC_W-1:0]   byte_cnt;
    logic [TO_W-1:0]   idle_cnt;
    logic              tick_start, tick_data, tick_stop;

    function automatic logic [PW-1:0] append_byte(input logic [PW-1:0] acc, input logic [7:0] b);
        if (MSB_FIRST != 0)
            return (acc << 8) | PW'(b);
        else
            return (acc >> 8) | (PW'(b) << (PW - 8));
    endfunction

    // The synchroniser resets to 1, so a line held low across reset would look like a
    // falling edge; edges are ignored until the chain has refilled with real samples.
    assign fall          = (settle == 2'd3) && rx_prev && !sync2;
    assign assembly_next = append_byte(assembly, shreg);
    assign busy          = (state != IDLE) || (byte_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        tick_start = 1'b0;
        tick_data  = 1'b0;
        tick_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (fall)
                    state_next = START;
            end
            START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    tick_start = 1'b1;
                    state_next = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    tick_data = 1'b1;
                    if (bit_idx == 3'd7)
                        state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    tick_stop  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            rx_prev     <= 1'b1;
            settle      <= 2'd0;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            assembly    <= '0;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            packet      <= '0;
            byte_data   <= '0;
            vld_out     <= 1'b0;
            byte_vld    <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            sync1       <= rx_in;
            sync2       <= sync1;
            rx_prev     <= sync2;
            vld_out     <= 1'b0;
            byte_vld    <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            if (settle != 2'd3)
                settle <= settle + 2'd1;

            if (state == IDLE || tick_start || tick_data)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            if (tick_start)
                bit_idx <= '0;
            else if (tick_data)
                bit_idx <= bit_idx + 3'd1;

            if (tick_data)
                shreg <= {sync2, shreg[7:1]};

            if (tick_stop) begin
                if (sync2) begin
                    byte_vld  <= 1'b1;
                    byte_data <= shreg;
                    if (byte_cnt == BC_W'(BYTES_PER_PKT - 1)) begin
                        packet   <= assembly_next;
                        vld_out  <= 1'b1;
                        assembly <= '0;
                        byte_cnt <= '0;
                    end else begin
                        assembly <= assembly_next;
                        byte_cnt <= byte_cnt + BC_W'(1);
                    end
                end else begin
                    frame_err <= 1'b1;
                    assembly  <= '0;
                    byte_cnt  <= '0;
                end
            end

            // Timeout only acts in IDLE, so it never collides with the stop-bit updates above;
            // a simultaneous falling edge still starts a new frame via the FSM.
            if (state == IDLE && byte_cnt != '0) begin
                if (idle_cnt == TO_W'(TO_CYC - 1)) begin
                    timeout_err <= 1'b1;
                    assembly    <= '0;
                    byte_cnt    <= '0;
                    idle_cnt    <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TO_W'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_assembler.sv
// Directed bench for uart_packet_assembler: an MSB-first and an LSB-first instance share one rx line.
module tb_uart_packet_assembler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_in = 1'b1;

    logic        m_vld_out, m_byte_vld, m_frame_err, m_timeout_err, m_busy;
    logic [31:0] m_packet;
    logic [7:0]  m_byte_data;
    logic        l_vld_out, l_byte_vld, l_frame_err, l_timeout_err, l_busy;
    logic [31:0] l_packet;
    logic [7:0]  l_byte_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_start = 0;

    int bv_cnt = 0, vld_cnt = 0, fe_cnt = 0, to_cnt = 0, lvld_cnt = 0;
    int bv_cyc = 0, to_cyc = 0, lvld_cyc = 0;
    logic [7:0] last_byte = 8'h00;

    uart_packet_assembler #(.CLKS_PER_BIT(32), .BYTES_PER_PKT(4), .MSB_FIRST(1), .TIMEOUT_BITS(20)) dut_m (
        .clk(clk), .reset(reset), .rx_in(rx_in), .vld_out(m_vld_out), .packet(m_packet),
        .byte_vld(m_byte_vld), .byte_data(m_byte_data), .frame_err(m_frame_err),
        .timeout_err(m_timeout_err), .busy(m_busy));

    uart_packet_assembler #(.CLKS_PER_BIT(32), .BYTES_PER_PKT(4), .MSB_FIRST(0), .TIMEOUT_BITS(20)) dut_l (
        .clk(clk), .reset(reset), .rx_in(rx_in), .vld_out(l_vld_out), .packet(l_packet),
        .byte_vld(l_byte_vld), .byte_data(l_byte_data), .frame_err(l_frame_err),
        .timeout_err(l_timeout_err), .busy(l_busy));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_byte_vld) begin
            bv_cnt++;
            bv_cyc = cyc;
            last_byte = m_byte_data;
        end
        if (m_vld_out) vld_cnt++;
        if (m_frame_err) fe_cnt++;
        if (m_timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (l_vld_out) begin
            lvld_cnt++;
            lvld_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        last_start = cyc;
        rx_in = 1'b0;
        idle(32);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            idle(32);
        end
        rx_in = stop;
        idle(32);
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        checks++;
        if ({m_vld_out, m_byte_vld, m_frame_err, m_timeout_err, m_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_m_flags: got %b expected 00000", {m_vld_out, m_byte_vld, m_frame_err, m_timeout_err, m_busy});
        end
        checks++;
        if (m_packet !== 32'h0 || m_byte_data !== 8'h0 || l_packet !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h expected 0", m_packet, m_byte_data, l_packet);
        end
        reset = 1'b0;
        idle(40);
    endtask

    task automatic test_basic();
        int bv0 = bv_cnt, v0 = vld_cnt, e0 = fe_cnt + to_cnt;
        send_byte(8'h3B, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h0F, 1'b1);
        idle(32);
        send_byte(8'h0F, 1'b1);
        idle(4);
        checks++;
        if (m_packet !== 32'h3B550F0F) begin
            errors++;
            $display("FAIL basic_msb_packet: got %h expected 3b550f0f", m_packet);
        end
        checks++;
        if (l_packet !== 32'h0F0F553B) begin
            errors++;
            $display("FAIL basic_lsb_packet: got %h expected 0f0f553b", l_packet);
        end
        checks++;
        if (bv_cnt - bv0 !== 4 || vld_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL basic_pulses: got byte_vld=%0d vld_out=%0d expected 4 and 1", bv_cnt - bv0, vld_cnt - v0);
        end
        checks++;
        if (fe_cnt + to_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL basic_errors: got %0d error pulses expected 0", fe_cnt + to_cnt - e0);
        end
        checks++;
        if (last_byte !== 8'h0F) begin
            errors++;
            $display("FAIL basic_byte_data: got %h expected 0f", last_byte);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [12] = '{8'h55, 8'h33, 8'hFF, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78,
                                    8'hA5, 8'h5A, 8'hC3, 8'h3C};
        logic [31:0] exp_l [3] = '{32'hF0FF3355, 32'h78563412, 32'h3CC35AA5};
        logic [31:0] exp_m [3] = '{32'h5533FFF0, 32'h12345678, 32'hA55AC33C};
        int lv0 = lvld_cnt;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) send_byte(bytes[4*p+k], 1'b1);
            checks++;
            if (l_packet !== exp_l[p] || m_packet !== exp_m[p]) begin
                errors++;
                $display("FAIL b2b_packet%0d: got %h/%h expected %h/%h", p, l_packet, m_packet, exp_l[p], exp_m[p]);
            end
            checks++;
            if (lvld_cyc - last_start !== 307) begin
                errors++;
                $display("FAIL b2b_latency%0d: got %0d expected 307 cycles from start edge", p, lvld_cyc - last_start);
            end
        end
        checks++;
        if (lvld_cnt - lv0 !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 3", lvld_cnt - lv0);
        end
    endtask

    task automatic test_frame_error();
        int f0 = fe_cnt, v0 = vld_cnt, bv0 = bv_cnt;
        send_byte(8'h3B, 1'b1);
        send_byte(8'h55, 1'b0);
        idle(32);
        send_byte(8'h0F, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h0F, 1'b1);
        idle(4);
        checks++;
        if (fe_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL frame_err_count: got %0d expected 1", fe_cnt - f0);
        end
        checks++;
        if (vld_cnt - v0 !== 1 || bv_cnt - bv0 !== 5) begin
            errors++;
            $display("FAIL frame_pulses: got vld_out=%0d byte_vld=%0d expected 1 and 5", vld_cnt - v0, bv_cnt - bv0);
        end
        checks++;
        if (m_packet !== 32'h0F0F330F || l_packet !== 32'h0F330F0F) begin
            errors++;
            $display("FAIL frame_packet: got %h/%h expected 0f0f330f/0f330f0f", m_packet, l_packet);
        end
    endtask

    task automatic test_timeout();
        int t0 = to_cnt, v0 = vld_cnt;
        send_byte(8'h3B, 1'b1);
        send_byte(8'h55, 1'b1);
        idle(700);
        checks++;
        if (to_cnt - t0 !== 1) begin
            errors++;
            $display("FAIL timeout_count: got %0d expected 1", to_cnt - t0);
        end
        checks++;
        if (to_cyc - bv_cyc !== 640) begin
            errors++;
            $display("FAIL timeout_cycle: got %0d expected 640 idle cycles", to_cyc - bv_cyc);
        end
        checks++;
        if (m_packet !== 32'h0F0F330F || vld_cnt - v0 !== 0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold: got packet=%h vld=%0d busy=%b expected 0f0f330f 0 0", m_packet, vld_cnt - v0, m_busy);
        end
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        idle(4);
        checks++;
        if (m_packet !== 32'h01020304 || l_packet !== 32'h04030201 || vld_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL timeout_fresh: got %h/%h vld=%0d expected 01020304/04030201 1", m_packet, l_packet, vld_cnt - v0);
        end
    endtask

    task automatic test_glitch();
        int bv0 = bv_cnt, f0 = fe_cnt;
        rx_in = 1'b0;
        idle(8);
        rx_in = 1'b1;
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high: got %b expected 1", m_busy);
        end
        idle(11);
        checks++;
        if (m_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_low: got %b expected 0", m_busy);
        end
        idle(400);
        checks++;
        if (bv_cnt - bv0 !== 0 || fe_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: got byte_vld=%0d frame_err=%0d expected 0 and 0", bv_cnt - bv0, fe_cnt - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0 = vld_cnt;
        send_byte(8'h11, 1'b1);
        rx_in = 1'b0;
        idle(32);
        rx_in = 1'b0;
        idle(32);
        rx_in = 1'b1;
        idle(32);
        reset = 1'b1;
        rx_in = 1'b1;
        idle(1);
        checks++;
        if (m_packet !== 32'h0 || l_packet !== 32'h0 || m_byte_data !== 8'h0 || m_busy !== 1'b0 || m_vld_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got packet=%h/%h byte=%h busy=%b vld=%b expected all 0",
                     m_packet, l_packet, m_byte_data, m_busy, m_vld_out);
        end
        reset = 1'b0;
        idle(64);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle(4);
        checks++;
        if (vld_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL midreset_vld_count: got %0d expected 1", vld_cnt - v0);
        end
        checks++;
        if (m_packet !== 32'hDEADBEEF || l_packet !== 32'hEFBEADDE) begin
            errors++;
            $display("FAIL midreset_packet: got %h/%h expected deadbeef/efbeadde", m_packet, l_packet);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_error();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
